// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC: arctangent table, gain, angle constants
// and the Q2.30 -> Q(FRAC) rescaling helper used to build per-stage constants.
package cordic_pkg;

    localparam logic CORDIC_ROT = 1'b0;
    localparam logic CORDIC_VEC = 1'b1;

    localparam logic [63:0] PI_Q30      = 64'd3373259426;
    localparam logic [63:0] HALF_PI_Q30 = 64'd1686629713;
    localparam logic [63:0] K_Q30       = 64'd652032875;

    // atan(2^-i) in Q2.30, rounded to nearest
    localparam logic [31:0] ATAN_Q30 [0:31] = '{
        32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
        32'd67021687,  32'd33543516,  32'd16775851,  32'd8388437,
        32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
        32'd262144,    32'd131072,    32'd65536,     32'd32768,
        32'd16384,     32'd8192,      32'd4096,      32'd2048,
        32'd1024,      32'd512,       32'd256,       32'd128,
        32'd64,        32'd32,        32'd16,        32'd8,
        32'd4,         32'd2,         32'd1,         32'd0
    };

    function automatic logic [63:0] q30_to_q(input logic [63:0] v, input int frac);
        logic [63:0] half;
        if (frac >= 30) begin
            return v << (frac - 30);
        end
        half = 64'd1 << (29 - frac);
        return (v + half) >> (30 - frac);
    endfunction

    function automatic logic [63:0] atan_q(input int i, input int frac);
        return q30_to_q({32'd0, ATAN_Q30[i]}, frac);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation by 2^-SHIFT; direction chosen from the
// sample's own mode so rotation and vectoring samples can be interleaved.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 15,
    parameter int TAG_W = 8,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic signed [WIDTH-1:0] ATAN = WIDTH'(atan_q(SHIFT, FRAC));

    logic signed [WIDTH-1:0] sx, sy, sz;
    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic signed [WIDTH-1:0] nx, ny, nz;
    logic                    d_pos;

    always_comb begin
        sx    = $signed(in_x);
        sy    = $signed(in_y);
        sz    = $signed(in_z);
        x_sh  = sx >>> SHIFT;
        y_sh  = sy >>> SHIFT;
        // rotation drives z toward zero, vectoring drives y toward zero
        d_pos = (in_mode == CORDIC_VEC) ? sy[WIDTH-1] : !sz[WIDTH-1];
        if (d_pos) begin
            nx = sx - y_sh;
            ny = sy + x_sh;
            nz = sz - ATAN;
        end else begin
            nx = sx + y_sh;
            ny = sy - x_sh;
            nz = sz + ATAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= CORDIC_ROT;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_x     <= nx;
            out_y     <= ny;
            out_z     <= nz;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined circular CORDIC (rotation/vectoring per sample) with quadrant pre-rotation.
// Define CORDIC_GAIN_COMP_EN to add an output stage that removes the CORDIC gain (one extra cycle).
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 15,
    parameter int ITER  = 16,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(q30_to_q(HALF_PI_Q30, FRAC));

    logic en;

    logic             v_s   [0:ITER];
    logic             m_s   [0:ITER];
    logic [WIDTH-1:0] x_s   [0:ITER];
    logic [WIDTH-1:0] y_s   [0:ITER];
    logic [WIDTH-1:0] z_s   [0:ITER];
    logic [TAG_W-1:0] tag_s [0:ITER];

    logic signed [WIDTH-1:0] sx, sy, sz;
    logic signed [WIDTH-1:0] px, py, pz;

    // single global stall: the whole pipe freezes while a result waits downstream
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        sx = $signed(in_x);
        sy = $signed(in_y);
        sz = $signed(in_z);
        px = sx;
        py = sy;
        pz = sz;
        if (in_mode == CORDIC_VEC) begin
            if (!sx[WIDTH-1]) begin
                pz = '0;
            end else if (!sy[WIDTH-1]) begin
                px = sy;
                py = -sx;
                pz = HALF_PI;
            end else begin
                px = -sy;
                py = sx;
                pz = -HALF_PI;
            end
        end else if (sz > HALF_PI) begin
            px = -sy;
            py = sx;
            pz = sz - HALF_PI;
        end else if (sz < -HALF_PI) begin
            px = sy;
            py = -sx;
            pz = sz + HALF_PI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s[0]   <= 1'b0;
            m_s[0]   <= CORDIC_ROT;
            x_s[0]   <= '0;
            y_s[0]   <= '0;
            z_s[0]   <= '0;
            tag_s[0] <= '0;
        end else if (en) begin
            v_s[0]   <= in_valid;
            m_s[0]   <= in_mode;
            x_s[0]   <= px;
            y_s[0]   <= py;
            z_s[0]   <= pz;
            tag_s[0] <= in_tag;
        end
    end

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .TAG_W (TAG_W),
            .SHIFT (i)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (v_s[i]),
            .in_mode   (m_s[i]),
            .in_x      (x_s[i]),
            .in_y      (y_s[i]),
            .in_z      (z_s[i]),
            .in_tag    (tag_s[i]),
            .out_valid (v_s[i+1]),
            .out_mode  (m_s[i+1]),
            .out_x     (x_s[i+1]),
            .out_y     (y_s[i+1]),
            .out_z     (z_s[i+1]),
            .out_tag   (tag_s[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [WIDTH-1:0] K_GAIN = WIDTH'(q30_to_q(K_Q30, FRAC));

    logic signed [2*WIDTH-1:0] kw, xw, yw, xk, yk;

    always_comb begin
        kw = {{WIDTH{K_GAIN[WIDTH-1]}}, K_GAIN};
        xw = {{WIDTH{x_s[ITER][WIDTH-1]}}, x_s[ITER]};
        yw = {{WIDTH{y_s[ITER][WIDTH-1]}}, y_s[ITER]};
        xk = xw * kw;
        yk = yw * kw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= v_s[ITER];
            out_x     <= WIDTH'(xk >>> FRAC);
            out_y     <= WIDTH'(yk >>> FRAC);
            out_z     <= z_s[ITER];
            out_tag   <= tag_s[ITER];
        end
    end
`else
    assign out_valid = v_s[ITER];
    assign out_x     = x_s[ITER];
    assign out_y     = y_s[ITER];
    assign out_z     = z_s[ITER];
    assign out_tag   = tag_s[ITER];
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed and streaming checks for cordic_pipe (WIDTH=32, FRAC=15, ITER=16);
// follows CORDIC_GAIN_COMP_EN to pick latency and expected magnitudes.
module tb_cordic_pipe;

    localparam int WIDTH = 32;
    localparam int FRAC  = 15;
    localparam int ITER  = 16;
    localparam int TAG_W = 8;
    localparam int TOL   = 8;
    localparam int HP    = 51472;
    localparam int AT [0:15] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                                 128, 64, 32, 16, 8, 4, 2, 1};
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT   = ITER + 2;
    localparam int E1_X  = 17232;
    localparam int E1_Y  = 9949;
    localparam int E2_X  = 46341;
    localparam int E3_X  = -23170;
    localparam int E3_Y  = 23170;
    localparam int E4_X  = 32768;
`else
    localparam int LAT   = ITER + 1;
    localparam int E1_X  = 28378;
    localparam int E1_Y  = 16384;
    localparam int E2_X  = 76312;
    localparam int E3_X  = -38156;
    localparam int E3_Y  = 38156;
    localparam int E4_X  = 53961;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_x, in_y, in_z;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x, out_y, out_z;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_tag   (out_tag)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model(input logic mode, input int x0, input int y0, input int z0,
                                  output int rx, output int ry, output int rz);
        int x, y, z, t, xs, ys;
        x = x0; y = y0; z = z0;
        if (mode) begin
            if (x >= 0) begin
                z = 0;
            end else if (y >= 0) begin
                t = x; x = y; y = -t; z = HP;
            end else begin
                t = x; x = -y; y = t; z = -HP;
            end
        end else if (z > HP) begin
            t = x; x = -y; y = t; z = z - HP;
        end else if (z < -HP) begin
            t = x; x = y; y = -t; z = z + HP;
        end
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (mode ? (y < 0) : (z >= 0)) begin
                x = x - ys; y = y + xs; z = z - AT[i];
            end else begin
                x = x + ys; y = y - xs; z = z + AT[i];
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        rx = int'((longint'(x) * 64'sd19898) >>> 15);
        ry = int'((longint'(y) * 64'sd19898) >>> 15);
`else
        rx = x;
        ry = y;
`endif
        rz = z;
    endfunction

    // single sample into an empty pipe with out_ready high; returns result and latency
    task automatic run_one(input logic mode, input int x, input int y, input int z,
                           input logic [TAG_W-1:0] tag,
                           output int rx, output int ry, output int rz,
                           output logic [TAG_W-1:0] rtag, output int lat);
        in_mode  = mode;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4 * LAT) begin
            @(posedge clk); #1;
            lat++;
        end
        rx   = $signed(out_x);
        ry   = $signed(out_y);
        rz   = $signed(out_z);
        rtag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if ({out_x, out_y, out_z, out_tag} !== '0) begin
            bad++; $display("FAIL reset_out_data got x=%0h y=%0h z=%0h tag=%0h want all 0",
                            out_x, out_y, out_z, out_tag);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_rotation();
        int rx, ry, rz, mx, my, mz, lat;
        logic [TAG_W-1:0] rt;
        run_one(1'b0, 19898, 0, 17157, 8'h11, rx, ry, rz, rt, lat);
        model(1'b0, 19898, 0, 17157, mx, my, mz);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL rot_latency got=%0d want=%0d", lat, LAT); end
        total++;
        if (iabs(rx - E1_X) > TOL) begin bad++; $display("FAIL rot_x got=%0d want=%0d", rx, E1_X); end
        total++;
        if (iabs(ry - E1_Y) > TOL) begin bad++; $display("FAIL rot_y got=%0d want=%0d", ry, E1_Y); end
        total++;
        if (iabs(rz) > TOL) begin bad++; $display("FAIL rot_z got=%0d want=0", rz); end
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h11) begin
            bad++; $display("FAIL rot_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,11", rx, ry, rz, rt, mx, my, mz);
        end
    endtask

    task automatic test_vectoring();
        int rx, ry, rz, mx, my, mz, lat;
        logic [TAG_W-1:0] rt;
        run_one(1'b1, 32768, 32768, 0, 8'h22, rx, ry, rz, rt, lat);
        model(1'b1, 32768, 32768, 0, mx, my, mz);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL vec_latency got=%0d want=%0d", lat, LAT); end
        total++;
        if (iabs(rz - 25736) > TOL) begin bad++; $display("FAIL vec_z got=%0d want=25736", rz); end
        total++;
        if (iabs(ry) > TOL) begin bad++; $display("FAIL vec_y got=%0d want=0", ry); end
        total++;
        if (iabs(rx - E2_X) > TOL) begin bad++; $display("FAIL vec_x got=%0d want=%0d", rx, E2_X); end
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h22) begin
            bad++; $display("FAIL vec_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,22", rx, ry, rz, rt, mx, my, mz);
        end
    endtask

    task automatic test_quadrant();
        int rx, ry, rz, mx, my, mz, lat;
        logic [TAG_W-1:0] rt;
        run_one(1'b0, 32768, 0, 77208, 8'h33, rx, ry, rz, rt, lat);
        model(1'b0, 32768, 0, 77208, mx, my, mz);
        total++;
        if (iabs(rx - E3_X) > TOL || iabs(ry - E3_Y) > TOL) begin
            bad++; $display("FAIL quad_rot got=%0d,%0d want=%0d,%0d", rx, ry, E3_X, E3_Y);
        end
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h33) begin
            bad++; $display("FAIL quad_rot_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,33", rx, ry, rz, rt, mx, my, mz);
        end
        run_one(1'b1, -32768, 0, 0, 8'h44, rx, ry, rz, rt, lat);
        model(1'b1, -32768, 0, 0, mx, my, mz);
        total++;
        if (iabs(rz - 102944) > TOL || iabs(rx - E4_X) > TOL) begin
            bad++; $display("FAIL quad_vec got z=%0d x=%0d want z=102944 x=%0d", rz, rx, E4_X);
        end
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h44) begin
            bad++; $display("FAIL quad_vec_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,44", rx, ry, rz, rt, mx, my, mz);
        end
        run_one(1'b1, -20000, -30000, 0, 8'h55, rx, ry, rz, rt, lat);
        model(1'b1, -20000, -30000, 0, mx, my, mz);
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h55) begin
            bad++; $display("FAIL quad_vec3_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,55", rx, ry, rz, rt, mx, my, mz);
        end
        run_one(1'b0, 12000, 5000, -90000, 8'h66, rx, ry, rz, rt, lat);
        model(1'b0, 12000, 5000, -90000, mx, my, mz);
        total++;
        if (rx !== mx || ry !== my || rz !== mz || rt !== 8'h66) begin
            bad++; $display("FAIL quad_rotneg_exact got=%0d,%0d,%0d,%0h want=%0d,%0d,%0d,66", rx, ry, rz, rt, mx, my, mz);
        end
    endtask

    task automatic test_stream();
        int qx[$], qy[$], qz[$];
        logic [TAG_W-1:0] qt[$];
        int rcv;
        int timeouts;
        rcv = 0;
        timeouts = 0;
        fork
            begin
                logic acc;
                int guard, x, y, z, mx, my, mz;
                logic m;
                for (int i = 0; i < 100; i++) begin
                    m = 1'($urandom_range(0, 1));
                    x = int'($urandom_range(0, 2097152)) - 1048576;
                    y = int'($urandom_range(0, 2097152)) - 1048576;
                    z = int'($urandom_range(0, 205888)) - 102944;
                    in_mode = m; in_x = x; in_y = y; in_z = z; in_tag = 8'(i);
                    in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 200);
                    if (!acc) timeouts++;
                    model(m, x, y, z, mx, my, mz);
                    qx.push_back(mx); qy.push_back(my); qz.push_back(mz); qt.push_back(8'(i));
                    in_valid = 1'b0;
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (rcv < 100 && cyc < 3000) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        total++;
                        if (qt.size() == 0) begin
                            bad++; $display("FAIL stream_extra got tag=%0d want none", out_tag);
                        end else begin
                            if (out_tag !== qt[0] || $signed(out_x) !== qx[0] ||
                                $signed(out_y) !== qy[0] || $signed(out_z) !== qz[0]) begin
                                bad++;
                                $display("FAIL stream_result got tag=%0d %0d,%0d,%0d want tag=%0d %0d,%0d,%0d",
                                         out_tag, $signed(out_x), $signed(out_y), $signed(out_z),
                                         qt[0], qx[0], qy[0], qz[0]);
                            end
                            void'(qt.pop_front()); void'(qx.pop_front());
                            void'(qy.pop_front()); void'(qz.pop_front());
                        end
                        rcv++;
                    end
                    cyc++;
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        total++;
        if (rcv !== 100 || timeouts !== 0) begin
            bad++; $display("FAIL stream_count got=%0d accept_timeouts=%0d want=100,0", rcv, timeouts);
        end
    endtask

    task automatic test_stall();
        int ex [0:31], ey [0:31], ez [0:31];
        int n, mx, my, mz, x, y, z;
        logic acc, stable, rdy_low, seq_ok;
        logic [WIDTH-1:0] hx, hy, hz;
        logic [TAG_W-1:0] ht;
        out_ready = 1'b0;
        n = 0;
        acc = 1'b1;
        while (acc && n < 32) begin
            in_mode = 1'(n % 2);
            x = 1000 * n + 3000; y = 500 - 700 * n; z = 6000 * n - 90000;
            in_x = x; in_y = y; in_z = z; in_tag = 8'(150 + n);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                model(1'(n % 2), x, y, z, mx, my, mz);
                ex[n] = mx; ey[n] = my; ez[n] = mz;
                n++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (n !== LAT) begin bad++; $display("FAIL stall_fill got=%0d want=%0d", n, LAT); end
        hx = out_x; hy = out_y; hz = out_z; ht = out_tag;
        stable = out_valid; rdy_low = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!out_valid || out_x !== hx || out_y !== hy || out_z !== hz || out_tag !== ht) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_low = 1'b0;
        end
        total++;
        if (stable !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b want=1", stable); end
        total++;
        if (rdy_low !== 1'b1) begin bad++; $display("FAIL stall_in_ready_low got=%b want=1", rdy_low); end
        out_ready = 1'b1;
        seq_ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!out_valid || out_tag !== 8'(150 + k) || $signed(out_x) !== ex[k] ||
                $signed(out_y) !== ey[k] || $signed(out_z) !== ez[k]) begin
                seq_ok = 1'b0;
                $display("note stall result %0d: valid=%b tag=%0d %0d,%0d,%0d", k, out_valid, out_tag,
                         $signed(out_x), $signed(out_y), $signed(out_z));
            end
        end
        total++;
        if (seq_ok !== 1'b1) begin bad++; $display("FAIL stall_release got=%b want=1", seq_ok); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b want=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_flush();
        int rx, ry, rz, mx, my, mz, lat;
        logic [TAG_W-1:0] rt;
        logic stale;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_mode = 1'b0; in_x = 20000; in_y = 100 * k; in_z = 1000 * k; in_tag = 8'(200 + k);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        stale = 1'b0;
        repeat (LAT + 8) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin bad++; $display("FAIL flush_stale got=%b want=0", stale); end
        run_one(1'b1, 15000, -8000, 0, 8'h77, rx, ry, rz, rt, lat);
        model(1'b1, 15000, -8000, 0, mx, my, mz);
        total++;
        if (lat !== LAT || rt !== 8'h77) begin
            bad++; $display("FAIL flush_first got lat=%0d tag=%0h want lat=%0d tag=77", lat, rt, LAT);
        end
        total++;
        if (rx !== mx || ry !== my || rz !== mz) begin
            bad++; $display("FAIL flush_value got=%0d,%0d,%0d want=%0d,%0d,%0d", rx, ry, rz, mx, my, mz);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_quadrant();
        test_stream();
        test_stall();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
